instr_dump: RTL
===============

INSTR_DUMP -- requirements
Module: instr_dump

Interface
REQ-001 Parameter: MAXWORDS, 1024, largest accepted word count; larger requests are clamped to it.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 n_rst  input  1  reset, asynchronous, active-low.
REQ-004 trig  input  1  one-cycle start pulse.
REQ-005 abort  input  1  one-cycle pulse; cancels a running dump.
REQ-006 startaddr  input  32  byte address of the first word; bits [1:0] are ignored and treated as 0.
REQ-007 nwords  input  11  number of words to dump; 0 means no-op.
REQ-008 busy  output  1  high while a dump is in progress.
REQ-009 memren  output  1  instruction-memory read enable.
REQ-010 memaddr  output  32  instruction-memory read byte address.
REQ-011 memdata  input  32  read data, valid on the cycle after memren.
REQ-012 uartbusy  input  1  transmitter busy.
REQ-013 uarttxen  output  1  one-cycle transmit strobe.
REQ-014 charout  output  8  character to transmit; stable whenever uarttxen is high.

Function
REQ-015 States: IDLE, READ, LATCH, SEND, TXWAIT, NEXT.
REQ-016 IDLE: trig with nwords != 0 -> READ. On that cycle latch startaddr & ~3 into the address register and min(nwords, MAXWORDS) into the remaining-word counter.
REQ-017 trig with nwords == 0 is ignored; the block stays in IDLE and busy stays 0.
REQ-018 trig while busy is ignored.
REQ-019 READ: memren = 1 for exactly one cycle with memaddr = address register -> LATCH.
REQ-020 LATCH: capture memdata into the data register and clear the character index -> SEND.
REQ-021 Each word is sent as one 19-character line: 8 hex digits of the address, ':' (0x3A), 8 hex digits of the data, CR (0x0D), LF (0x0A). Hex digits go most significant nibble first.
REQ-022 Hex encoding: nibble 0-9 -> 0x30+n; nibble 10-15 -> 0x41+(n-10), i.e. uppercase.
REQ-023 SEND: wait while uartbusy = 1. When uartbusy = 0, assert uarttxen for exactly one cycle with charout = character[index] -> TXWAIT.
REQ-024 TXWAIT: ignore uartbusy on the first cycle, then wait for uartbusy = 0.
REQ-025 From TXWAIT: if index < 18, increment the index -> SEND; if index = 18 -> NEXT.
REQ-026 NEXT: decrement the remaining-word counter and add 4 to the address register, which wraps modulo 2^32 (0xFFFFFFFC -> 0x00000000). If the counter reaches 0 -> IDLE, otherwise -> READ.
REQ-027 busy = 1 in every state except IDLE.
REQ-028 memren and uarttxen are never high in the same cycle.
REQ-029 abort in any non-IDLE state -> IDLE on the next edge. uarttxen is forced to 0 from that edge onward; a character already strobed is not recalled.
REQ-030 abort and trig in the same cycle while in IDLE: trig wins.
REQ-031 Throughput: exactly one memory read per word; no character is ever repeated or skipped.

Reset
REQ-032 n_rst low asynchronously forces state IDLE and sets busy, memren, uarttxen and charout to 0. The address register, data register, counter and index also clear to 0.
REQ-033 Reset mid-dump discards all progress; the next trig after release starts a fresh dump.
REQ-034 No output toggles during the first edge after n_rst is released.

Structure
REQ-035 The shared package holds the state encoding, the CR/LF/colon character constants and the line length constant (19).
REQ-036 One sub-module, nib2hex (4-bit in, 8-bit ASCII out, combinational), performs the hex encoding.
REQ-037 Character selection is a mux on the index over address and data nibbles; charout is registered.

Verification
REQ-038 Basic dump: startaddr = 0x00000000, nwords = 1, mem[0] = 0xDEADBEEF -> the 19-character string "00000000:DEADBEEF\r\n", then busy falls.
REQ-039 Multi-word, unaligned start: startaddr = 0x00000FFE, nwords = 2 -> lines start at 0x00000FFC and 0x00001000; memren pulses exactly twice.
REQ-040 Address wrap: startaddr = 0xFFFFFFFC, nwords = 2 -> the second line starts "00000000:".
REQ-041 Backpressure: hold uartbusy high for 100 cycles after each strobe -> no uarttxen pulse while uartbusy is high; exactly 19 strobes per word.
REQ-042 Edge cases: trig with nwords = 0 -> busy is never set. nwords = 2047 -> exactly 1024 lines. trig during a dump -> ignored.
REQ-043 Interruption: abort after the 5th character -> IDLE next cycle, with no further strobes. A separate run with n_rst asserted mid-dump -> all outputs 0 immediately, and a new trig then gives a full correct dump.

Source files
------------

// File: rtl/instr_dump_pkg.sv
// rtl/instr_dump_pkg.sv - shared constants for the instruction memory dumper
// Contents: FSM state encoding, ASCII framing characters, dump line length.
package instr_dump_pkg;

  // FSM state encoding
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_LATCH  = 3'd2;
  localparam logic [2:0] S_SEND   = 3'd3;
  localparam logic [2:0] S_TXWAIT = 3'd4;
  localparam logic [2:0] S_NEXT   = 3'd5;

  // Framing characters of one dump line
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  // "AAAAAAAA:DDDDDDDD\r\n"
  localparam int         LINE_LEN = 19;
  localparam logic [4:0] LAST_IDX = 5'(LINE_LEN - 1);
  localparam logic [4:0] COLON_IDX = 5'd8;
  localparam logic [4:0] CR_IDX    = 5'd17;

endpackage

// File: rtl/instr_dump_nib2hex.sv
// rtl/instr_dump_nib2hex.sv - combinational nibble to uppercase ASCII hex digit
// Ports:
//   nib   in  4  nibble value 0..15
//   ascii out 8  '0'..'9' or 'A'..'F'
module instr_dump_nib2hex (
  input  logic [3:0] nib,
  output logic [7:0] ascii
);

  // 'A' + (n - 10) == 0x37 + n
  always_comb begin
    if (nib < 4'd10) begin
      ascii = 8'h30 + {4'd0, nib};
    end else begin
      ascii = 8'h37 + {4'd0, nib};
    end
  end

endmodule

// File: rtl/instr_dump.sv
// rtl/instr_dump.sv - dumps instruction memory words as hex text lines to a UART
// Ports:
//   clk, n_rst          clock, asynchronous active-low reset
//   trig, abort         start pulse, cancel pulse
//   startaddr, nwords   first byte address (low 2 bits ignored), word count (0 = no-op)
//   busy                high while a dump is running
//   memren, memaddr     memory read strobe and byte address
//   memdata             read data, valid the cycle after memren
//   uartbusy            transmitter busy
//   uarttxen, charout   one-cycle transmit strobe and the character it carries
module instr_dump
  import instr_dump_pkg::*;
#(
  parameter int MAXWORDS = 1024
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        trig,
  input  logic        abort,
  input  logic [31:0] startaddr,
  input  logic [10:0] nwords,
  output logic        busy,
  output logic        memren,
  output logic [31:0] memaddr,
  input  logic [31:0] memdata,
  input  logic        uartbusy,
  output logic        uarttxen,
  output logic [7:0]  charout
);

  logic [2:0]  state_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [10:0] cnt_q;
  logic [4:0]  idx_q;
  logic        first_q;
  logic        txen_q;
  logic [7:0]  char_q;
  logic        armed_q;

  logic [10:0] nwords_clamped;
  logic [63:0] word_pair;
  logic [3:0]  nib_num;
  logic [5:0]  nib_pos;
  logic [3:0]  nib;
  logic [7:0]  hex_char;
  logic [7:0]  char_sel;

  assign nwords_clamped = (int'(nwords) > MAXWORDS) ? 11'(MAXWORDS) : nwords;

  // Address and data digits form one 16-nibble string; the colon at index 8
  // splits them, so data digits sit one index higher than their nibble number.
  assign word_pair = {addr_q, data_q};

  always_comb begin
    nib_num = 4'd0;
    if (idx_q < COLON_IDX) begin
      nib_num = idx_q[3:0];
    end else begin
      nib_num = 4'(idx_q - 5'd1);
    end
  end

  assign nib_pos = {4'd15 - nib_num, 2'b00};
  assign nib     = word_pair[nib_pos +: 4];

  instr_dump_nib2hex u_nib2hex (
    .nib   (nib),
    .ascii (hex_char)
  );

  always_comb begin
    char_sel = hex_char;
    if (idx_q == COLON_IDX) begin
      char_sel = CH_COLON;
    end else if (idx_q == CR_IDX) begin
      char_sel = CH_CR;
    end else if (idx_q == LAST_IDX) begin
      char_sel = CH_LF;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      first_q <= 1'b0;
      txen_q  <= 1'b0;
      char_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      // strobe lasts one cycle; also kills any strobe on an abort edge
      txen_q  <= 1'b0;
      // the first edge after reset release never starts a dump
      armed_q <= 1'b1;
      if ((state_q != S_IDLE) && abort) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (trig && armed_q && (nwords != 11'd0)) begin
              addr_q  <= {startaddr[31:2], 2'b00};
              cnt_q   <= nwords_clamped;
              state_q <= S_READ;
            end
          end
          S_READ: begin
            state_q <= S_LATCH;
          end
          S_LATCH: begin
            data_q  <= memdata;
            idx_q   <= '0;
            state_q <= S_SEND;
          end
          S_SEND: begin
            if (!uartbusy) begin
              txen_q  <= 1'b1;
              char_q  <= char_sel;
              first_q <= 1'b1;
              state_q <= S_TXWAIT;
            end
          end
          S_TXWAIT: begin
            // the transmitter cannot report busy until it has seen the strobe
            if (first_q) begin
              first_q <= 1'b0;
            end else if (!uartbusy) begin
              if (idx_q == LAST_IDX) begin
                state_q <= S_NEXT;
              end else begin
                idx_q   <= idx_q + 5'd1;
                state_q <= S_SEND;
              end
            end
          end
          S_NEXT: begin
            cnt_q   <= cnt_q - 11'd1;
            addr_q  <= addr_q + 32'd4;
            state_q <= (cnt_q == 11'd1) ? S_IDLE : S_READ;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign memren   = (state_q == S_READ);
  assign memaddr  = addr_q;
  assign uarttxen = txen_q;
  assign charout  = char_q;

endmodule
